// File: rtl/note_sequencer.sv
// note_sequencer: mmap bus initiator that plays one note per command.
// Define NOTE_SEQ_TIMEOUT_EN to bound NOTE_FINISHED polling by POLL_TIMEOUT.
module note_sequencer #(
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_fcw,
  input  logic [15:0] cmd_hold,
  input  logic        abort,
  output logic        en,
  output logic [15:0] addr,
  output logic [2:0]  MMap_Sel,
  output logic [31:0] data,
  input  logic [31:0] MMap_dout,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] notes_done
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FCW,
    WR_START,
    HOLD,
    WR_REL,
    POLL_ISSUE,
    POLL_WAIT,
    WR_RST
  } state_t;

  localparam logic [2:0] SEL_LOAD  = 3'd1;
  localparam logic [2:0] SEL_STORE = 3'd2;
  localparam logic [2:0] SEL_IDLE  = 3'd6;

  state_t      state;
  logic [23:0] fcw_q;
  logic [15:0] hold_q;
  logic [15:0] hold_cnt;
  logic [15:0] done_q;
  logic        finished;
  logic        abortable;

  assign finished  = MMap_dout[0];
  assign abortable = (state != IDLE) && (state != WR_RST);

`ifdef NOTE_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt;
  logic [16:0] poll_nxt;
  logic        to_q;
  logic [31:0] unused_dout;

  assign poll_nxt    = {1'b0, poll_cnt} + 17'd1;
  assign timeout_err = to_q;
  assign unused_dout = {MMap_dout[31:1], 1'b0};
`else
  logic [31:0] unused_dout;
  localparam int unused_poll_timeout = POLL_TIMEOUT;

  assign timeout_err = 1'b0;
  assign unused_dout = {MMap_dout[31:1], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fcw_q    <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      done_q   <= '0;
`ifdef NOTE_SEQ_TIMEOUT_EN
      poll_cnt <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            fcw_q  <= cmd_fcw;
            hold_q <= cmd_hold;
            state  <= WR_FCW;
          end
        end
        WR_FCW: state <= WR_START;
        WR_START: begin
          hold_cnt <= hold_q;
          state    <= (hold_q == 16'd0) ? WR_REL : HOLD;
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 16'd1;
          if (hold_cnt == 16'd1)
            state <= WR_REL;
        end
        WR_REL: begin
`ifdef NOTE_SEQ_TIMEOUT_EN
          poll_cnt <= '0;
`endif
          state <= POLL_ISSUE;
        end
        POLL_ISSUE: begin
`ifdef NOTE_SEQ_TIMEOUT_EN
          poll_cnt <= poll_nxt[15:0];
`endif
          state <= POLL_WAIT;
        end
        POLL_WAIT: begin
`ifdef NOTE_SEQ_TIMEOUT_EN
          poll_cnt <= poll_nxt[15:0];
`endif
          if (finished) begin
            done_q <= done_q + 16'd1;
            state  <= WR_RST;
`ifdef NOTE_SEQ_TIMEOUT_EN
          end else if (poll_nxt >= 17'(POLL_TIMEOUT)) begin
            to_q  <= 1'b1;
            state <= WR_RST;
`endif
          end else begin
            state <= POLL_ISSUE;
          end
        end
        WR_RST: state <= IDLE;
        default: state <= IDLE;
      endcase
      // abort beats every other transition, including a same-cycle finish
      if (abort && abortable) begin
        state  <= WR_RST;
        done_q <= done_q;
`ifdef NOTE_SEQ_TIMEOUT_EN
        to_q   <= to_q;
`endif
      end
    end
  end

  always_comb begin
    en       = 1'b0;
    addr     = 16'h0000;
    MMap_Sel = SEL_IDLE;
    data     = 32'h0;
    unique case (state)
      WR_FCW: begin
        en       = 1'b1;
        addr     = 16'h1000;
        MMap_Sel = SEL_STORE;
        data     = {8'h0, fcw_q};
      end
      WR_START: begin
        en       = 1'b1;
        addr     = 16'h1004;
        MMap_Sel = SEL_STORE;
      end
      WR_REL: begin
        en       = 1'b1;
        addr     = 16'h1008;
        MMap_Sel = SEL_STORE;
      end
      POLL_ISSUE: begin
        en       = 1'b1;
        addr     = 16'h100c;
        MMap_Sel = SEL_LOAD;
      end
      WR_RST: begin
        en       = 1'b1;
        addr     = 16'h1010;
        MMap_Sel = SEL_STORE;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign notes_done = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: random notes vs. a timeline model, scoreboarded
// bus events; a monitor answers NOTE_FINISHED polls.
module tb_note_sequencer;

`ifdef NOTE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_fcw = '0;
  logic [15:0] cmd_hold = '0;
  logic        abort = 1'b0;
  logic        en;
  logic [15:0] addr;
  logic [2:0]  MMap_Sel;
  logic [31:0] data;
  logic [31:0] MMap_dout = '0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] notes_done;

  note_sequencer #(.POLL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fcw(cmd_fcw), .cmd_hold(cmd_hold),
    .abort(abort), .en(en), .addr(addr),
    .MMap_Sel(MMap_Sel), .data(data),
    .MMap_dout(MMap_dout), .busy(busy),
    .timeout_err(timeout_err), .notes_done(notes_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t q[$];
  int  npass = 0;
  int  ntot = 0;
  int  cur_k = 0;
  int  exp_done = 0;
  bit  exp_to = 1'b0;
  bit  mon_on = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic push(int c, logic [2:0] s, logic [15:0] a, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.sel = s; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // Monitor: answers polls, pops/compares every bus event, checks idle bus
  initial begin
    bit prev_load = 1'b0;
    int pidx = 0;
    logic [31:0] r;
    ev_t e;
    wait (mon_on);
    forever begin
      @(posedge clk); #1;
      r = $urandom;
      r[0] = prev_load ? (pidx == cur_k) : 1'b1;
      if (prev_load) pidx++;
      MMap_dout = r;
      if (en) begin
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_bus: got sel %0d addr 0x%0h, expected none (cycle %0d)",
                   MMap_Sel, addr, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", 32'(cyc), 32'(e.cyc));
          chk("ev_sel", {29'b0, MMap_Sel}, {29'b0, e.sel});
          chk("ev_addr", {16'b0, addr}, {16'b0, e.addr});
          chk("ev_data", data, e.data);
        end
      end else begin
        chk("idle_sel", {29'b0, MMap_Sel}, 32'd6);
        chk("idle_addr", {16'b0, addr}, 32'd0);
        chk("idle_data", data, 32'd0);
      end
      if (en && MMap_Sel == 3'd2 && addr == 16'h1000) pidx = 0;
      prev_load = en && MMap_Sel == 3'd1 && addr == 16'h100c;
    end
  end

  // hold cycles, k = polls reading 0 before finished, ab = abort cycle (0 none)
  task automatic run_note(logic [23:0] fcw, int hold, int k, int ab, bit ab_idle);
    int a, rel, rstc;
    bit to, hit;
    rel = 3 + hold;
    rstc = rel + 3 + 2 * k;
    to = 1'b0;
    hit = 1'b0;
    if (TO_EN && k >= 4) begin
      rstc = rel + 9;
      to = 1'b1;
    end
    if (ab > 0 && ab < rstc) begin
      rstc = ab + 1;
      to = 1'b0;
      hit = 1'b1;
    end else begin
      ab = 0;
    end
    chk("ready_before", {31'b0, cmd_ready}, 32'd1);
    a = cyc;
    cur_k = k;
    cmd_valid = 1'b1;
    cmd_fcw = fcw;
    cmd_hold = 16'(hold);
    abort = ab_idle;
    push(a + 1, 3'd2, 16'h1000, {8'h0, fcw});
    if (2 < rstc) push(a + 2, 3'd2, 16'h1004, 32'd0);
    if (rel < rstc) push(a + rel, 3'd2, 16'h1008, 32'd0);
    for (int t = rel + 1; t < rstc; t += 2) push(a + t, 3'd1, 16'h100c, 32'd0);
    push(a + rstc, 3'd2, 16'h1010, 32'd0);
    if (!hit && !to) exp_done++;
    if (to) exp_to = 1'b1;
    for (int r = 1; r <= rstc + 1; r++) begin
      @(posedge clk); #1;
      if (r == 1) begin
        cmd_valid = 1'b0;
        abort = 1'b0;
        cmd_fcw = 24'($urandom);
        cmd_hold = 16'($urandom);
      end
      if (ab > 0 && r == ab) abort = 1'b1;
      if (ab > 0 && r == ab + 2) abort = 1'b0;
      if (r == rstc) chk("ready_low", {31'b0, cmd_ready}, 32'd0);
    end
    chk("ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("notes_done", {16'b0, notes_done}, 32'(exp_done[15:0]));
    chk("timeout_err", {31'b0, timeout_err}, {31'b0, exp_to});
  endtask

  task automatic reset_mid_poll();
    int a;
    a = cyc;
    cur_k = 100;
    cmd_valid = 1'b1;
    cmd_fcw = 24'h123456;
    cmd_hold = 16'd1;
    push(a + 1, 3'd2, 16'h1000, 32'h00123456);
    push(a + 2, 3'd2, 16'h1004, 32'd0);
    push(a + 4, 3'd2, 16'h1008, 32'd0);
    push(a + 5, 3'd1, 16'h100c, 32'd0);
    for (int r = 1; r <= 6; r++) begin
      @(posedge clk); #1;
      if (r == 1) cmd_valid = 1'b0;
      if (r == 5) rst = 1'b1;
      if (r == 6) rst = 1'b0;
    end
    exp_done = 0;
    exp_to = 1'b0;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {16'b0, notes_done}, 32'd0);
    chk("rst_to", {31'b0, timeout_err}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, k, ab;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_en", {31'b0, en}, 32'd0);
    chk("reset_sel", {29'b0, MMap_Sel}, 32'd6);
    chk("reset_addr", {16'b0, addr}, 32'd0);
    chk("reset_to", {31'b0, timeout_err}, 32'd0);
    chk("reset_done", {16'b0, notes_done}, 32'd0);
    mon_on = 1'b1;

    run_note(24'h00ABCD, 4, 0, 0, 1'b0);
    run_note(24'($urandom), 0, 0, 0, 1'b0);
    run_note(24'($urandom), 2, 3, 0, 1'b1);
    run_note(24'($urandom), 5, 0, 4, 1'b0);
    if (TO_EN) begin
      run_note(24'($urandom), 1, 6, 0, 1'b0);
      run_note(24'($urandom), 2, 0, 0, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      hold = $urandom_range(0, 6);
      k = $urandom_range(0, TO_EN ? 5 : 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
      run_note(24'($urandom), hold, k, ab, 1'($urandom));
    end
    reset_mid_poll();
    run_note(24'h0F00F0, 1, 1, 0, 1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

- Single-clock bus initiator that plays notes on the synth's memory-mapped register file without CPU involvement.
- Accepts one note command at a time (FCW plus hold time) over a valid/ready handshake.
- Drives the same addr/MMap_Sel/data/en bus the CPU uses: stores FCW, pulses NOTE_START, waits, pulses NOTE_RELEASE, polls NOTE_FINISHED, then pulses NOTE_RESET.
- Sits beside the CPU datapath; a top-level mux (outside this block) selects which initiator owns the mmap bus.

## Interface
Parameters:
- POLL_TIMEOUT, 65535: max cycles spent polling NOTE_FINISHED before forced reset (used only with timeout compiled in).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  note command available.
- cmd_ready  output  1  high only in IDLE.
- cmd_fcw  input  24  frequency control word; latched on accept.
- cmd_hold  input  16  cycles between NOTE_START and NOTE_RELEASE stores; latched on accept.
- abort  input  1  level; forces early NOTE_RESET.
- en  output  1  high in every cycle with a LOAD or STORE, else 0.
- addr  output  16  mmap address.
- MMap_Sel  output  3  1 = LOAD, 2 = STORE, 6 = idle (no-op, not counted as an instruction).
- data  output  32  store data.
- MMap_dout  input  32  load data, valid the cycle after a LOAD.
- busy  output  1  state != IDLE.
- timeout_err  output  1  sticky; cleared only by rst.
- notes_done  output  16  count of notes that completed normally; wraps 0xFFFF -> 0.

## Operation
- Moore machine. Bus outputs decode from the state register and latched fcw only.
- Idle bus values: addr = 0x0000, MMap_Sel = 6, data = 0, en = 0. The mmap side decodes note pulses from addr alone, so addr must never rest on 0x1004/0x1008/0x1010 outside their one-cycle states.
- IDLE: on cmd_valid && cmd_ready, latch fcw/hold, go to WR_FCW.
- WR_FCW: STORE, addr 0x1000, data = {8'h0, fcw}. Next: WR_START.
- WR_START: STORE, addr 0x1004, data 0. Load hold counter. Next: HOLD, or WR_REL if hold = 0.
- HOLD: idle bus; decrement. Leave when counter reaches 1 (exactly cmd_hold HOLD cycles). Next: WR_REL.
- WR_REL: STORE, addr 0x1008. Clear poll counter. Next: POLL_ISSUE.
- POLL_ISSUE: LOAD, addr 0x100c. Next: POLL_WAIT.
- POLL_WAIT: idle bus; sample MMap_dout[0].
  - If 1: notes_done++ and go to WR_RST.
  - Else: go to POLL_ISSUE (2-cycle poll period).
- WR_RST: STORE, addr 0x1010, data 0. Next: IDLE.
- Abort:
  - If high in WR_FCW..POLL_WAIT: next state is WR_RST and notes_done is not incremented. This overrides all other transitions, including a finished sample in the same cycle.
  - Ignored in IDLE and WR_RST. A command presented in IDLE with abort high is still accepted.
- Reset mid-note: state returns to IDLE immediately and no NOTE_RESET store is issued. notes_done = 0, timeout_err = 0, counters = 0.

## Timing
- Accept at cycle 0.
- FCW store at cycle 1; START at cycle 2.
- RELEASE at cycle 3 + hold.
- First poll LOAD at cycle 4 + hold; its sample at cycle 5 + hold.
- If finished on the first poll, RESET store at cycle 6 + hold and cmd_ready high at cycle 7 + hold.
- Reset values: cmd_ready = 1, busy = 0, idle bus values, timeout_err = 0, notes_done = 0.

## Configuration
- NOTE_SEQ_TIMEOUT_EN defined:
  - A poll counter increments every POLL_ISSUE/POLL_WAIT cycle.
  - When it reaches POLL_TIMEOUT in POLL_WAIT without finished = 1: set timeout_err, go to WR_RST, notes_done unchanged.
- Not defined: no counter exists, polling continues until finished or abort, and timeout_err is tied to 0.

## Test plan
- fcw = 0x00ABCD, hold = 4, finished = 1 on first poll:
  - Bus sequence is STORE 0x1000 data 0x00ABCD (cyc 1), STORE 0x1004 (2), idle for cyc 3-6, STORE 0x1008 (7), LOAD 0x100c (8), STORE 0x1010 (10).
  - notes_done = 1.
- hold = 0: RELEASE store directly follows START (cycles 2, 3).
- finished held at 0 for 3 polls, then 1: exactly 4 LOADs at 2-cycle spacing, then one RESET store.
- abort asserted during HOLD: next cycle is STORE 0x1010, then IDLE; no RELEASE store; notes_done unchanged.
- With NOTE_SEQ_TIMEOUT_EN, POLL_TIMEOUT = 8, finished stuck at 0: RESET store issued, timeout_err = 1 and remains 1 through the next normal note, until rst.
- rst asserted mid-POLL: the next cycle shows idle bus, cmd_ready = 1, notes_done = 0, and no 0x1010 store.
